// File: rtl/pio_capture_pkg.sv
// Shared constants for the input-capture PIO: register word addresses and edge-select codes.
package pio_capture_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE    = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_input_capture_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a stable-count debouncer.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic sync,
  output logic stable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic meta_q;
  logic sync_q;
  logic stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any sample that agrees with the accepted state restarts the count, so short glitches die here.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign sync   = sync_q;
  assign stable = stable_q;

endmodule

// File: rtl/pio_input_capture.sv
// Debounced input PIO with sticky edge capture, maskable level irq and a 4-word Avalon-MM slave.
module pio_input_capture
  import pio_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] pins_norm;
  logic [WIDTH-1:0] sync_vec;
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] rise, fall, hit;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_sel;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             unused_wdata;

  assign pins_norm = (ACTIVE_LOW != 0) ? ~pins_in : pins_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (pins_norm[i]),
      .sync   (sync_vec[i]),
      .stable (stable_vec[i])
    );
  end

  assign rise = stable_vec & ~stable_dly_q;
  assign fall = ~stable_vec & stable_dly_q;

  always_comb begin
    hit = rise;
    case (EDGE_TYPE)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_ANY:  hit = rise | fall;
      default:   hit = rise;
    endcase
  end

  // A fresh edge overrides a same-cycle W1C so an event is never lost.
  always_comb begin
    w1c    = '0;
    mask_d = mask_q;
    if (avs_write && avs_address == ADDR_EDGE) begin
      w1c = avs_writedata[WIDTH-1:0];
    end
    if (avs_write && avs_address == ADDR_IRQMASK) begin
      mask_d = avs_writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~w1c) | hit;
    irq_d  = |(edge_q & mask_q);
  end

  always_comb begin
    rd_sel = '0;
    unique case (avs_address)
      ADDR_DATA:    rd_sel = stable_vec;
      ADDR_IRQMASK: rd_sel = mask_q;
      ADDR_EDGE:    rd_sel = edge_q;
      ADDR_RAW:     rd_sel = sync_vec;
      default:      rd_sel = '0;
    endcase
    readdata_d = avs_read ? 32'(rd_sel) : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      edge_q       <= '0;
      mask_q       <= '0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable_vec;
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

  assign unused_wdata = ^avs_writedata;
  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pio_input_capture.sv
// Directed bench for pio_input_capture with DEBOUNCE_CYCLES=4, WIDTH=4, rising edges, active-low pins.
module tb_pio_input_capture;
  import pio_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  pins_in;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #10 clk = ~clk;

  pio_input_capture #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (0),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pins_in      (pins_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe a read for one cycle; the registered result is visible at the following negedge.
  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    check(tag, avs_readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rdwr_chk(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp,
                          input string tag);
    avs_address   = a;
    avs_writedata = d;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check(tag, avs_readdata, exp);
  endtask

  initial begin
    reset_n       = 1'b0;
    pins_in       = 4'hF;
    avs_address   = 2'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    tick(2);
    check("reset_rdata", avs_readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;

    rd_chk(ADDR_DATA, 32'h0, "init_data");
    rd_chk(ADDR_IRQMASK, 32'h0, "init_mask");
    rd_chk(ADDR_EDGE, 32'h0, "init_edge");
    check("init_irq", {31'h0, irq}, 32'h0);
    tick(10);
    rd_chk(ADDR_DATA, 32'h0, "idle_data");
    rd_chk(ADDR_RAW, 32'h0, "idle_raw");

    // Press bit 0: stable flips after the 6th edge, edge bit one edge later.
    pins_in = 4'hE;
    tick(5);
    rd_chk(ADDR_DATA, 32'h0, "press0_e6");
    rd_chk(ADDR_DATA, 32'h1, "press0_e7");
    rd_chk(ADDR_EDGE, 32'h1, "press0_edge");
    check("press0_irq_masked", {31'h0, irq}, 32'h0);
    rd_chk(ADDR_RAW, 32'h1, "press0_raw");

    wr(ADDR_IRQMASK, 32'h1);
    check("mask_irq_lag", {31'h0, irq}, 32'h0);
    tick(1);
    check("mask_irq_up", {31'h0, irq}, 32'h1);
    wr(ADDR_EDGE, 32'h1);
    check("w1c_irq_lag", {31'h0, irq}, 32'h1);
    tick(1);
    check("w1c_irq_down", {31'h0, irq}, 32'h0);
    rd_chk(ADDR_EDGE, 32'h0, "w1c_edge");

    wr(ADDR_DATA, 32'hFFFF_FFFF);
    rd_chk(ADDR_DATA, 32'h1, "data_ro");
    rdwr_chk(ADDR_IRQMASK, 32'hFFFF_FFFF, 32'h1, "rdwr_prewrite");
    rd_chk(ADDR_IRQMASK, 32'hF, "mask_width");
    wr(ADDR_IRQMASK, 32'h1);

    // 3-cycle glitch on bit 1 must be rejected.
    pins_in = 4'hC;
    tick(3);
    pins_in = 4'hE;
    tick(10);
    rd_chk(ADDR_DATA, 32'h1, "glitch3_data");
    rd_chk(ADDR_EDGE, 32'h0, "glitch3_edge");

    // 4-cycle pulse is just long enough.
    pins_in = 4'hC;
    tick(4);
    pins_in = 4'hE;
    tick(2);
    rd_chk(ADDR_EDGE, 32'h0, "pulse4_edge_e7");
    rd_chk(ADDR_EDGE, 32'h2, "pulse4_edge_e8");
    rd_chk(ADDR_DATA, 32'h3, "pulse4_data");
    tick(10);
    rd_chk(ADDR_DATA, 32'h1, "pulse4_released");
    wr(ADDR_EDGE, 32'h2);
    rd_chk(ADDR_EDGE, 32'h0, "pulse4_cleared");
    check("pulse4_irq", {31'h0, irq}, 32'h0);

    // W1C lands on the same edge as a new rising edge of bit 1.
    pins_in = 4'hC;
    tick(6);
    wr(ADDR_EDGE, 32'h2);
    rd_chk(ADDR_EDGE, 32'h2, "set_wins");

    pins_in = 4'hE;
    tick(10);
    pins_in = 4'hA;
    tick(10);
    rd_chk(ADDR_EDGE, 32'h6, "two_pending");
    pins_in = 4'h8;
    tick(6);
    wr(ADDR_EDGE, 32'h6);
    rd_chk(ADDR_EDGE, 32'h2, "set_wins_mixed");
    check("mixed_irq", {31'h0, irq}, 32'h0);

    // Reset in the middle of a bit-2 debounce.
    pins_in = 4'hF;
    tick(10);
    pins_in = 4'hB;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    check("midrst_rdata", avs_readdata, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    rd_chk(ADDR_DATA, 32'h0, "postrst_data");
    rd_chk(ADDR_IRQMASK, 32'h0, "postrst_mask");
    rd_chk(ADDR_EDGE, 32'h0, "postrst_edge");
    tick(2);
    rd_chk(ADDR_DATA, 32'h0, "postrst_e6");
    rd_chk(ADDR_DATA, 32'h4, "postrst_e7");
    rd_chk(ADDR_EDGE, 32'h4, "postrst_edge2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
